pe_psum_ctrl: RTL and testbench

Sequencing controller for one row-stationary PE. It walks the filter-tap and output-position loops of a 1-D convolution and drives the ifmap, filter and psum scratchpad addresses. It issues the 3-phase read/MAC/write strobes for every step. At the end of a pass it drains the finished psums to the array through a valid/ready port. It sits inside PE_control and replaces the free-running psum address counter, with explicit loop bounds and stall handling.

---
 rtl/pe_ctrl_pkg.sv | 24 ++
 rtl/pe_phase_ctr.sv | 41 ++++
 rtl/pe_psum_ctrl.sv | 156 +++++++++++++++
 tb/tb_pe_psum_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// ============================================================================
// Module   : pe_ctrl_pkg
// Purpose  : Shared state and phase encodings for the PE psum controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } pe_state_e;

  // Sub-steps of one (o,k) step: spad read, multiply, psum write-back.
  localparam logic [1:0] PH_RD  = 2'd0;
  localparam logic [1:0] PH_MAC = 2'd1;
  localparam logic [1:0] PH_WR  = 2'd2;

endpackage : pe_ctrl_pkg

`default_nettype wire

// File: rtl/pe_phase_ctr.sv
// ============================================================================
// Module   : pe_phase_ctr
// Purpose  : Mod-3 read/MAC/write phase counter; in_valid gates phase 0 only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_phase_ctr
  import pe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_in_valid,
  output logic [1:0] o_phase,
  output logic       o_tc
);

  logic [1:0] r_phase;
  logic       w_adv;

  // Phase 0 waits for spad data; the MAC and write phases never stall.
  assign w_adv = i_en && ((r_phase != PH_RD) || i_in_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= PH_RD;
    end else if (i_clr) begin
      r_phase <= PH_RD;
    end else if (w_adv) begin
      r_phase <= (r_phase == PH_WR) ? PH_RD : r_phase + 2'd1;
    end
  end

  assign o_phase = r_phase;
  assign o_tc    = w_adv && (r_phase == PH_WR);

endmodule : pe_phase_ctr

`default_nettype wire

// File: rtl/pe_psum_ctrl.sv
// ============================================================================
// Module   : pe_psum_ctrl
// Purpose  : Row-stationary PE sequencer: k/o loop walk, strobes, psum drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_psum_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int IADDR_W = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_filt_len,
  input  logic [ADDR_W-1:0]  cfg_ofmap_len,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [IADDR_W-1:0] ifmap_addr,
  output logic [ADDR_W-1:0]  filt_addr,
  output logic [ADDR_W-1:0]  psum_addr,
  output logic               spad_rd_en,
  output logic               mac_en,
  output logic               psum_rd_en,
  output logic               psum_wr_en,
  output logic               acc_first,
  output logic               out_valid
);

  pe_state_e         r_state;
  logic [ADDR_W-1:0] r_filt_len;
  logic [ADDR_W-1:0] r_ofmap_len;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_o;
  logic [ADDR_W-1:0] r_d;

  logic [1:0]        w_phase;
  logic              w_tc;
  logic              w_in_compute;
  logic              w_k_last;
  logic              w_o_last;
  logic              w_d_last;
  logic              w_cfg_zero;

  assign w_in_compute = (r_state == COMPUTE);
  assign w_k_last     = (r_k == r_filt_len  - ADDR_W'(1));
  assign w_o_last     = (r_o == r_ofmap_len - ADDR_W'(1));
  assign w_d_last     = (r_d == r_ofmap_len - ADDR_W'(1));
  assign w_cfg_zero   = (cfg_filt_len == '0) || (cfg_ofmap_len == '0);

  pe_phase_ctr u_phase_ctr (
    .clk        (clk),
    .rstn       (rstn),
    .i_en       (w_in_compute),
    .i_clr      (!w_in_compute),
    .i_in_valid (in_valid),
    .o_phase    (w_phase),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_filt_len  <= '0;
      r_ofmap_len <= '0;
      r_k         <= '0;
      r_o         <= '0;
      r_d         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_filt_len  <= cfg_filt_len;
            r_ofmap_len <= cfg_ofmap_len;
            r_k         <= '0;
            r_o         <= '0;
            r_d         <= '0;
            r_state     <= w_cfg_zero ? DONE : COMPUTE;
          end
        end
        COMPUTE: begin
          // Loop indices only move once the write phase of a step retires.
          if (w_tc) begin
            if (w_k_last) begin
              r_k <= '0;
              if (w_o_last) begin
                r_d     <= '0;
                r_state <= DRAIN;
              end else begin
                r_o <= r_o + ADDR_W'(1);
              end
            end else begin
              r_k <= r_k + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (w_d_last) begin
              r_state <= DONE;
            end else begin
              r_d <= r_d + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    spad_rd_en = 1'b0;
    mac_en     = 1'b0;
    psum_rd_en = 1'b0;
    psum_wr_en = 1'b0;
    acc_first  = 1'b0;
    if (w_in_compute) begin
      case (w_phase)
        PH_RD: begin
          spad_rd_en = in_valid;
        end
        PH_MAC: begin
          mac_en     = 1'b1;
          psum_rd_en = (r_k != '0);
        end
        PH_WR: begin
          psum_wr_en = 1'b1;
          acc_first  = (r_k == '0);
        end
        default: begin
          spad_rd_en = 1'b0;
        end
      endcase
    end
  end

  // Addresses are forced to zero outside the states that own them, so reset is clean.
  assign ifmap_addr = w_in_compute ? (IADDR_W'(r_o) + IADDR_W'(r_k)) : '0;
  assign filt_addr  = w_in_compute ? r_k : '0;
  assign psum_addr  = w_in_compute ? r_o : ((r_state == DRAIN) ? r_d : '0);
  assign out_valid  = (r_state == DRAIN);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);

endmodule : pe_psum_ctrl

`default_nettype wire

// File: tb/tb_pe_psum_ctrl.sv
// ============================================================================
// Module   : tb_pe_psum_ctrl
// Purpose  : Scoreboard bench for pe_psum_ctrl with a per-cycle reference schedule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_psum_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cfg_filt_len = '0;
  logic [3:0] cfg_ofmap_len = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, spad_rd_en, mac_en, psum_rd_en, psum_wr_en, acc_first, out_valid;
  logic [4:0] ifmap_addr;
  logic [3:0] filt_addr, psum_addr;

  pe_psum_ctrl #(.ADDR_W(4), .IADDR_W(5)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_filt_len(cfg_filt_len), .cfg_ofmap_len(cfg_ofmap_len),
    .in_valid(in_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .ifmap_addr(ifmap_addr), .filt_addr(filt_addr),
    .psum_addr(psum_addr), .spad_rd_en(spad_rd_en), .mac_en(mac_en),
    .psum_rd_en(psum_rd_en), .psum_wr_en(psum_wr_en), .acc_first(acc_first),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, done, rd, mac, prd, pwr, accf, ov;
    logic       cmp_io, cmp_ps;
    logic [4:0] ifm;
    logic [3:0] filt, psum;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   peak_ifm = 0;
  int   pass_cyc = 0;
  int   abort_at = -1;
  bit   aborted = 1'b0;

  task automatic check(input exp_t e);
    logic ok;
    ok = ({busy, done, spad_rd_en, mac_en, psum_rd_en, psum_wr_en, acc_first, out_valid} ==
          {e.busy, e.done, e.rd, e.mac, e.prd, e.pwr, e.accf, e.ov});
    if (e.cmp_io) ok = ok && (ifmap_addr == e.ifm) && (filt_addr == e.filt);
    if (e.cmp_ps) ok = ok && (psum_addr == e.psum);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL cycle_rec t=%0t ctl(busy,done,rd,mac,prd,pwr,accf,ov) act=%b req=%b ifm act=%0d req=%0d filt act=%0d req=%0d psum act=%0d req=%0d",
               $time, {busy, done, spad_rd_en, mac_en, psum_rd_en, psum_wr_en, acc_first, out_valid},
               {e.busy, e.done, e.rd, e.mac, e.prd, e.pwr, e.accf, e.ov},
               ifmap_addr, e.ifm, filt_addr, e.filt, psum_addr, e.psum);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  // Monitor: pops one expected record per cycle the driver scheduled.
  initial begin
    forever begin
      @(negedge clk);
      if (spad_rd_en && int'(ifmap_addr) > peak_ifm) peak_ifm = int'(ifmap_addr);
      if (q.size() > 0) check(q.pop_front());
    end
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic drive(input logic iv, input logic orr, input logic st, input bit noise, input exp_t e);
    if (aborted) return;
    if (pass_cyc == abort_at) begin
      aborted = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    in_valid  = iv;
    out_ready = orr;
    start     = st;
    if (noise) begin
      cfg_filt_len  = 4'($urandom_range(0, 15));
      cfg_ofmap_len = 4'($urandom_range(0, 15));
    end
    q.push_back(e);
    pass_cyc++;
  endtask

  // Reference schedule for one pass: step-level loop walk with explicit stall counts.
  task automatic run_pass(input int f, input int o_len, input int st_step, input int st_len,
                          input int dr_idx, input int dr_len, input bit rnd, input bit noise,
                          input int abort);
    exp_t e;
    int   s;
    pass_cyc      = 0;
    abort_at      = abort;
    aborted       = 1'b0;
    cfg_filt_len  = 4'(f);
    cfg_ofmap_len = 4'(o_len);
    e = '0;
    drive(rb(), rb(), 1'b1, 1'b0, e);
    if (f == 0 || o_len == 0) begin
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      drive(rb(), rb(), 1'b0, 1'b0, e);
      return;
    end
    for (int o = 0; o < o_len; o++) begin
      for (int k = 0; k < f; k++) begin
        s = 0;
        if (rnd && $urandom_range(0, 3) == 0) s = $urandom_range(1, 3);
        if (o * f + k == st_step) s = st_len;
        e = '0; e.busy = 1'b1; e.cmp_io = 1'b1; e.cmp_ps = 1'b1;
        e.ifm = 5'(o + k); e.filt = 4'(k); e.psum = 4'(o);
        for (int i = 0; i < s; i++) drive(1'b0, rb(), noise ? rb() : 1'b0, noise, e);
        e.rd = 1'b1;
        drive(1'b1, rb(), noise ? rb() : 1'b0, noise, e);
        e.rd = 1'b0; e.mac = 1'b1; e.prd = (k != 0);
        drive(rb(), rb(), noise ? rb() : 1'b0, noise, e);
        e.mac = 1'b0; e.prd = 1'b0; e.pwr = 1'b1; e.accf = (k == 0);
        drive(rb(), rb(), noise ? rb() : 1'b0, noise, e);
      end
    end
    for (int d = 0; d < o_len; d++) begin
      s = 0;
      if (rnd && $urandom_range(0, 2) == 0) s = $urandom_range(1, 3);
      if (d == dr_idx) s = dr_len;
      e = '0; e.busy = 1'b1; e.ov = 1'b1; e.cmp_ps = 1'b1; e.psum = 4'(d);
      for (int i = 0; i < s; i++) drive(rb(), 1'b0, 1'b0, 1'b0, e);
      drive(rb(), 1'b1, 1'b0, 1'b0, e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    drive(rb(), rb(), 1'b0, 1'b0, e);
  endtask

  initial begin
    exp_t e;
    #2;
    check_val("reset_outputs_zero",
              int'({busy, done, spad_rd_en, mac_en, psum_rd_en, psum_wr_en, acc_first, out_valid,
                    ifmap_addr, filt_addr, psum_addr}), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    run_pass(3, 4, -1, 0, -1, 0, 1'b0, 1'b0, -1);
    run_pass(3, 4, 5, 5, -1, 0, 1'b0, 1'b0, -1);
    run_pass(3, 4, -1, 0, 2, 3, 1'b0, 1'b0, -1);
    run_pass(3, 0, -1, 0, -1, 0, 1'b0, 1'b0, -1);
    run_pass(0, 5, -1, 0, -1, 0, 1'b0, 1'b0, -1);
    run_pass(3, 4, -1, 0, -1, 0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 10; i++)
      run_pass($urandom_range(1, 6), $urandom_range(1, 6), -1, 0, -1, 0, 1'b1, i[0], -1);

    peak_ifm = 0;
    run_pass(15, 15, -1, 0, -1, 0, 1'b0, 1'b0, -1);
    e = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, e);
    @(negedge clk);
    check_val("ifmap_addr_peak", peak_ifm, 28);

    // Abandon a pass mid-compute with an asynchronous reset.
    run_pass(3, 4, -1, 0, -1, 0, 1'b0, 1'b0, 20);
    @(posedge clk);
    #3 rstn = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check_val("async_reset_outputs_zero",
              int'({busy, done, spad_rd_en, mac_en, psum_rd_en, psum_wr_en, acc_first, out_valid,
                    ifmap_addr, filt_addr, psum_addr}), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("no_wr_in_reset", int'({psum_wr_en, busy}), 0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_val("idle_after_reset", int'({busy, psum_wr_en, out_valid}), 0);

    run_pass(1, 2, -1, 0, -1, 0, 1'b0, 1'b0, -1);
    e = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, e);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_pe_psum_ctrl

`default_nettype wire
